// File: rtl/mu0_seq_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mu0_seq_alu: registered MU0 ALU with N/Z/C/V flags and valid/ready intake.  |
// | Shifts are iterative when MU0_ALU_SHIFT_EN is defined; otherwise M=6/7 pass X.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mu0_seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Q,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cin;
  logic             w_cout;
  logic             w_c;
  logic             w_v;
  logic             w_start_shift;
  logic             w_load;

  logic [WIDTH-1:0] r_q;
  logic             r_n;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic             r_out_valid;

  // One shared adder: add uses Y, increment uses 0+1, subtract uses ~Y+1.
  always_comb begin
    w_b   = '0;
    w_cin = 1'b0;
    case (M)
      3'd1:    w_b = Y;
      3'd2:    w_cin = 1'b1;
      3'd3: begin
        w_b   = ~Y;
        w_cin = 1'b1;
      end
      default: w_b = '0;
    endcase
    {w_cout, w_sum} = {1'b0, X} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  end

  always_comb begin
    w_res = X;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (M)
      3'd0: w_res = Y;
      3'd1, 3'd2, 3'd3: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_v   = (X[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != X[WIDTH-1]);
      end
      3'd4: w_res = X & Y;
      3'd5: w_res = X | Y;
      default: w_res = X;
    endcase
  end

`ifdef MU0_ALU_SHIFT_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_arith;
  logic [WIDTH-1:0] w_sh_res;
  logic             w_sh_c;
  logic             w_shift_done;

  assign In_Ready      = (r_state == S_IDLE);
  assign w_start_shift = In_Valid && In_Ready && (M[2:1] == 2'b11) && (Y[SHW-1:0] != '0);
  assign w_load        = In_Valid && In_Ready && !w_start_shift;
  assign w_shift_done  = (r_state == S_SHIFT) && (r_cnt == SHW'(1));

  always_comb begin
    if (r_arith) begin
      w_sh_res = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      w_sh_c   = r_work[0];
    end else begin
      w_sh_res = {r_work[WIDTH-2:0], 1'b0};
      w_sh_c   = r_work[WIDTH-1];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_arith <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_shift) begin
            r_work  <= X;
            r_cnt   <= Y[SHW-1:0];
            r_arith <= M[0];
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_sh_res;
          r_cnt  <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign In_Ready      = 1'b1;
  assign w_start_shift = 1'b0;
  assign w_load        = In_Valid && !w_start_shift;
`endif

  // Result and flags only move together with an Out_Valid pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q         <= '0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_load) begin
        r_q         <= w_res;
        r_n         <= w_res[WIDTH-1];
        r_z         <= (w_res == '0);
        r_c         <= w_c;
        r_v         <= w_v;
        r_out_valid <= 1'b1;
      end
`ifdef MU0_ALU_SHIFT_EN
      else if (w_shift_done) begin
        r_q         <= w_sh_res;
        r_n         <= w_sh_res[WIDTH-1];
        r_z         <= (w_sh_res == '0);
        r_c         <= w_sh_c;
        r_v         <= 1'b0;
        r_out_valid <= 1'b1;
      end
`endif
    end
  end

  assign Q         = r_q;
  assign N         = r_n;
  assign Z         = r_z;
  assign C         = r_c;
  assign V         = r_v;
  assign Out_Valid = r_out_valid;

endmodule
`default_nettype wire
